// File: rtl/div_pkg.sv
// Shared definitions for the sequential RV64M divider: operation encodings,
// FSM states, width constants and special-case result values.
package div_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = $clog2(XLEN) + 1;

    // bit1 selects remainder, bit0 selects unsigned
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } div_state_e;

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtraction for one restoring-division step: (W+1)-bit partial
// remainder minus zero-extended divisor magnitude, with a borrow/negative flag.
module div_trial_sub #(
    parameter int W = 64
) (
    input  logic [W:0]   minuend,
    input  logic [W-1:0] subtrahend,
    output logic [W-1:0] diff,
    output logic         neg
);

    logic [W:0] full;

    // The partial remainder is always below twice the divisor, so a positive
    // difference fits in W bits and bit W is a reliable sign.
    assign full = minuend - {1'b0, subtrahend};
    assign diff = full[W-1:0];
    assign neg  = full[W];

endmodule

// File: rtl/seq_divider_64.sv
// Multi-cycle 64-bit restoring divider for DIV/DIVU/REM/REMU with a
// start/busy/done handshake, flush kill and early-out special cases.
module seq_divider_64
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    div_state_e       state, state_n;
    logic             op_rem, op_rem_n;
    logic             neg_q, neg_q_n;
    logic             neg_r, neg_r_n;
    logic [XLEN-1:0]  div_mag, div_mag_n;
    logic [XLEN-1:0]  quo, quo_n;
    logic [XLEN-1:0]  rem, rem_n;
    logic [XLEN-1:0]  result_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             done_n;

    logic             is_signed, a_neg, b_neg, overflow;
    logic [XLEN:0]    shifted;
    logic [XLEN-1:0]  trial;
    logic             trial_neg;

    assign is_signed = (op == OP_DIV) || (op == OP_REM);
    assign a_neg     = is_signed & dividend[XLEN-1];
    assign b_neg     = is_signed & divisor[XLEN-1];
    assign overflow  = is_signed && (dividend == MIN_NEG) && (divisor == ALL_ONES);

    // {R,Q} shifted left by one: the quotient MSB moves into the remainder
    assign shifted = {rem, quo[XLEN-1]};

    div_trial_sub #(.W(XLEN)) u_trial (
        .minuend    (shifted),
        .subtrahend (div_mag),
        .diff       (trial),
        .neg        (trial_neg)
    );

    assign busy = (state != S_IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_n   = state;
        op_rem_n  = op_rem;
        neg_q_n   = neg_q;
        neg_r_n   = neg_r;
        div_mag_n = div_mag;
        quo_n     = quo;
        rem_n     = rem;
        cnt_n     = cnt;
        result_n  = result;
        done_n    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start && !flush) begin
                    op_rem_n  = op[1];
                    cnt_n     = '0;
                    div_mag_n = b_neg ? -divisor : divisor;
                    if (divisor == '0) begin
                        // Final values are preset unsigned-clean; FIX adds no sign
                        quo_n   = ALL_ONES;
                        rem_n   = dividend;
                        neg_q_n = 1'b0;
                        neg_r_n = 1'b0;
                        state_n = S_FIX;
                    end else if (overflow) begin
                        quo_n   = MIN_NEG;
                        rem_n   = '0;
                        neg_q_n = 1'b0;
                        neg_r_n = 1'b0;
                        state_n = S_FIX;
                    end else begin
                        quo_n   = a_neg ? -dividend : dividend;
                        rem_n   = '0;
                        neg_q_n = a_neg ^ b_neg;
                        neg_r_n = a_neg;
                        state_n = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (flush) begin
                    state_n = S_IDLE;
                end else begin
                    quo_n = {quo[XLEN-2:0], ~trial_neg};
                    rem_n = trial_neg ? shifted[XLEN-1:0] : trial;
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        state_n = S_FIX;
                    end
                end
            end

            S_FIX: begin
                if (flush) begin
                    state_n = S_IDLE;
                end else begin
                    result_n = op_rem ? (neg_r ? -rem : rem)
                                      : (neg_q ? -quo : quo);
                    done_n   = 1'b1;
                    state_n  = S_IDLE;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            op_rem  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div_mag <= '0;
            quo     <= '0;
            rem     <= '0;
            cnt     <= '0;
            result  <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            op_rem  <= op_rem_n;
            neg_q   <= neg_q_n;
            neg_r   <= neg_r_n;
            div_mag <= div_mag_n;
            quo     <= quo_n;
            rem     <= rem_n;
            cnt     <= cnt_n;
            result  <= result_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_seq_divider_64.sv
// Self-checking bench for seq_divider_64: directed spec cases, randomized ops
// against an arithmetic reference model, handshake, flush and async reset.
module tb_seq_divider_64;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        busy, done;
    logic [63:0] result;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_divider_64 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Reference: RISC-V division semantics with plain SV arithmetic
    function automatic logic [63:0] ref_div(input logic [1:0] o, input logic [63:0] a,
                                            input logic [63:0] b);
        logic signed [63:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 64'd0) return o[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        if (!o[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
            return o[1] ? 64'd0 : a;
        if (o[0]) return o[1] ? (a % b) : (a / b);
        return o[1] ? 64'(sa % sb) : 64'(sa / sb);
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [63:0] a,
                                       input logic [63:0] b);
        if (b == 64'd0) return 1;
        if (!o[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
        return 65;
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = {$urandom, $urandom};
            1:       v = 64'($urandom_range(0, 20));
            2:       v = 64'd0 - 64'($urandom_range(1, 20));
            3:       v = 64'h8000_0000_0000_0000;
            4:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            5:       v = 64'd1 << $urandom_range(0, 63);
            6:       v = {$urandom, $urandom} >> $urandom_range(0, 63);
            default: v = 64'd0 - ({$urandom, $urandom} >> $urandom_range(1, 63));
        endcase
        return v;
    endfunction

    // Drive start for one edge (E0); returns #1 after E0
    task automatic launch(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen #1 after an edge; lat=-1 on timeout
    task automatic wait_done(output logic [63:0] res, output int lat);
        res = '0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                res = result;
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        checks++;
        if (result !== 64'd0) begin
            failures++;
            $display("FAIL reset_result: got %h expected 0", result);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op  [11] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_REM, OP_DIVU,
                                    OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_DIVU};
        logic [63:0] t_a   [11] = '{64'd100, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
                                    64'hFFFF_FFFF_FFFF_FFF9, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF,
                                    64'd5, 64'd5, 64'h8000_0000_0000_0000,
                                    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        logic [63:0] t_b   [11] = '{64'd7, 64'd7, 64'd2, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE,
                                    64'd1, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                                    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        logic [63:0] t_exp [11] = '{64'd14, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD,
                                    64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
                                    64'hFFFF_FFFF_FFFF_FFFF, 64'd5,
                                    64'h8000_0000_0000_0000, 64'd0, 64'd0};
        int          t_lat [11] = '{65, 65, 65, 65, 65, 65, 1, 1, 1, 1, 65};
        logic [63:0] res;
        int          lat;
        for (int i = 0; i < 11; i++) begin
            launch(t_op[i], t_a[i], t_b[i]);
            wait_done(res, lat);
            checks++;
            if (res !== t_exp[i]) begin
                failures++;
                $display("FAIL directed_%0d_result: got %h expected %h", i, res, t_exp[i]);
            end
            checks++;
            if (lat !== t_lat[i]) begin
                failures++;
                $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, t_lat[i]);
            end
            if (i == 0) begin
                @(posedge clk);
                #1;
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL done_pulse_width: got done=%b busy=%b expected 0 0",
                             done, busy);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [63:0] a, b, res, exp_res;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = rand_operand();
            b = rand_operand();
            exp_res = ref_div(o, a, b);
            launch(o, a, b);
            wait_done(res, lat);
            checks++;
            if (res !== exp_res || lat !== ref_latency(o, a, b)) begin
                failures++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got %h lat %0d expected %h lat %0d",
                         i, o, a, b, res, lat, exp_res, ref_latency(o, a, b));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  o;
        logic [63:0] a, b, res, exp_res;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            o = 2'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            b = 64'($urandom_range(1, 1000));
            exp_res = ref_div(o, a, b);
            launch(o, a, b);
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_%0d_busy_after_start: got %b expected 1", i, busy);
            end
            wait_done(res, lat);
            checks++;
            if (res !== exp_res || lat !== 65 || busy !== 1'b0) begin
                failures++;
                $display("FAIL b2b_%0d: got %h lat %0d busy %b expected %h lat 65 busy 0",
                         i, res, lat, busy, exp_res);
            end
        end
    endtask

    task automatic test_ignore_and_flush();
        logic [63:0] res;
        int          lat, seen;
        // New start 10 cycles into an op must not disturb it
        launch(OP_DIVU, 64'd100, 64'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = OP_DIV; dividend = 64'd12345; divisor = 64'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(res, lat);
        checks++;
        if (res !== 64'd14 || lat + 10 !== 65) begin
            failures++;
            $display("FAIL start_while_busy: got %h lat %0d expected 000000000000000e lat 65",
                     res, lat + 10);
        end
        // Flush 30 cycles in: no done, result kept
        launch(OP_DIVU, {$urandom, $urandom}, 64'($urandom_range(1, 99)));
        repeat (29) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy: got busy=%b done=%b expected 0 0", busy, done);
        end
        seen = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || result !== 64'd14) begin
            failures++;
            $display("FAIL flush_no_done: got %0d dones result %h expected 0 dones result e",
                     seen, result);
        end
        // flush together with start in IDLE drops the start
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = OP_DIVU; dividend = 64'd50; divisor = 64'd5;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_drops_start: got busy=%b expected 0", busy);
        end
        launch(OP_DIVU, 64'd9, 64'd3);
        wait_done(res, lat);
        checks++;
        if (res !== 64'd3 || lat !== 65) begin
            failures++;
            $display("FAIL after_flush_divu: got %h lat %0d expected 3 lat 65", res, lat);
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] a, b, res, exp_res;
        int          lat, seen;
        launch(OP_REM, {$urandom, $urandom}, 64'($urandom_range(2, 500)));
        repeat (39) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0) begin
            failures++;
            $display("FAIL async_reset: got busy=%b done=%b result=%h expected 0 0 0",
                     busy, done, result);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_no_done: got %0d dones expected 0", seen);
        end
        a = 64'd0 - 64'($urandom_range(1000, 100000));
        b = 64'($urandom_range(3, 97));
        exp_res = ref_div(OP_DIV, a, b);
        launch(OP_DIV, a, b);
        wait_done(res, lat);
        checks++;
        if (res !== exp_res || lat !== 65) begin
            failures++;
            $display("FAIL after_reset_div: got %h lat %0d expected %h lat 65", res, lat, exp_res);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_and_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
